// File: rtl/filter_window_gen.sv
// Streaming 3x3 window generator: two line buffers plus a 3x3 shift window,
// emitting a registered 72-bit window for every interior pixel of a raster frame.
module filter_window_gen #(
    parameter int WIDTH  = 64,
    parameter int HEIGHT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  pixel_in,
    input  logic        pixel_valid,
    input  logic        frame_start,
    output logic [71:0] window_out,
    output logic        window_valid,
    output logic        frame_done
);

    localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    logic [CW-1:0] col_q, col_d, col_cur;
    logic [RW-1:0] row_q, row_d, row_cur;
    logic          last_col, last_row;

    logic [7:0]    lb0_mem [WIDTH];
    logic [7:0]    lb1_mem [WIDTH];
    logic [7:0]    top_pix, mid_pix;
    logic [7:0]    new_col [3];

    logic [71:0]   win_q, win_d;
    logic [71:0]   window_out_q;
    logic          window_valid_q, window_valid_d;
    logic          frame_done_q, frame_done_d;

    // frame_start overrides the counters for the pixel it accompanies
    always_comb begin
        col_cur = frame_start ? '0 : col_q;
        row_cur = frame_start ? '0 : row_q;
    end

    assign last_col = (col_cur == CW'(WIDTH - 1));
    assign last_row = (row_cur == RW'(HEIGHT - 1));

    // Same-cycle read of the old contents; the write lands at the clock edge
    assign top_pix    = lb1_mem[col_cur];
    assign mid_pix    = lb0_mem[col_cur];
    assign new_col[0] = top_pix;
    assign new_col[1] = mid_pix;
    assign new_col[2] = pixel_in;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_row
            assign win_d[gi*24 +  0 +: 8] = win_q[gi*24 +  8 +: 8];
            assign win_d[gi*24 +  8 +: 8] = win_q[gi*24 + 16 +: 8];
            assign win_d[gi*24 + 16 +: 8] = new_col[gi];
        end
    endgenerate

    always_comb begin
        col_d          = col_q;
        row_d          = row_q;
        window_valid_d = 1'b0;
        frame_done_d   = 1'b0;
        if (pixel_valid) begin
            window_valid_d = (row_cur >= RW'(2)) && (col_cur >= CW'(2));
            frame_done_d   = last_col && last_row;
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_cur + RW'(1);
            end else begin
                col_d = col_cur + CW'(1);
                row_d = row_cur;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q          <= '0;
            row_q          <= '0;
            win_q          <= '0;
            window_out_q   <= '0;
            window_valid_q <= 1'b0;
            frame_done_q   <= 1'b0;
        end else begin
            col_q          <= col_d;
            row_q          <= row_d;
            window_valid_q <= window_valid_d;
            frame_done_q   <= frame_done_d;
            if (pixel_valid) begin
                win_q <= win_d;
            end
            if (window_valid_d) begin
                window_out_q <= win_d;
            end
        end
    end

    // Line buffers carry no reset; counters keep stale contents from being flagged
    always_ff @(posedge clk) begin
        if (pixel_valid && !rst) begin
            lb1_mem[col_cur] <= mid_pix;
            lb0_mem[col_cur] <= pixel_in;
        end
    end

    assign window_out   = window_out_q;
    assign window_valid = window_valid_q;
    assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_filter_window_gen.sv
// Self-checking bench: 4x4 and 5x3 instances, table-driven ramp plus
// scoreboarded multi-frame, gap, reset and frame-restart sequences.
module tb_filter_window_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  pix_a, pix_b;
    logic        pv_a, pv_b, fs_a, fs_b;
    logic [71:0] w_a, w_b;
    logic        wv_a, wv_b, fd_a, fd_b;

    int cyc = 0;
    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        logic [71:0] w;
        logic        d;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [7:0]  pix;
        logic        fs;
        bit          ev;
        logic [71:0] ew;
        bit          ed;
    } vec_t;

    exp_t q_a[$];
    exp_t q_b[$];
    vec_t tbl[16];
    int   img[4][4];

    filter_window_gen #(.WIDTH(4), .HEIGHT(4)) dut_a (
        .clk(clk), .rst(rst), .pixel_in(pix_a), .pixel_valid(pv_a),
        .frame_start(fs_a), .window_out(w_a), .window_valid(wv_a), .frame_done(fd_a)
    );

    filter_window_gen #(.WIDTH(5), .HEIGHT(3)) dut_b (
        .clk(clk), .rst(rst), .pixel_in(pix_b), .pixel_valid(pv_b),
        .frame_start(fs_b), .window_out(w_b), .window_valid(wv_b), .frame_done(fd_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [71:0] w9(input int b0, input int b1, input int b2,
                                       input int b3, input int b4, input int b5,
                                       input int b6, input int b7, input int b8);
        return {8'(b8), 8'(b7), 8'(b6), 8'(b5), 8'(b4), 8'(b3), 8'(b2), 8'(b1), 8'(b0)};
    endfunction

    task automatic check(input string name, input logic [71:0] got, input logic [71:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // Monitors: pop one expectation per window_valid pulse
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (wv_a) begin
                if (q_a.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_window_A: got %h expected no window", w_a);
                end else begin
                    e = q_a.pop_front();
                    $display("A window %h done=%0b cycle=%0d", w_a, fd_a, cyc);
                    check("window_A", w_a, e.w);
                    check("done_A", 72'(fd_a), 72'(e.d));
                    check("latency_A", 72'(cyc), 72'(e.cyc));
                end
            end else if (fd_a) begin
                n_total++;
                $display("FAIL done_without_window_A: got 1 expected 0");
            end
            if (wv_b) begin
                if (q_b.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_window_B: got %h expected no window", w_b);
                end else begin
                    e = q_b.pop_front();
                    $display("B window %h done=%0b cycle=%0d", w_b, fd_b, cyc);
                    check("window_B", w_b, e.w);
                    check("done_B", 72'(fd_b), 72'(e.d));
                    check("latency_B", 72'(cyc), 72'(e.cyc));
                end
            end else if (fd_b) begin
                n_total++;
                $display("FAIL done_without_window_B: got 1 expected 0");
            end
        end
    end

    task automatic drv_a(input logic [7:0] pix, input logic fs, input bit ev,
                         input logic [71:0] ew, input bit ed);
        exp_t e;
        pix_a = pix;
        fs_a  = fs;
        pv_a  = 1'b1;
        if (ev) begin
            e.w = ew; e.d = ed; e.cyc = cyc + 1;
            q_a.push_back(e);
        end
        @(posedge clk); #1;
        pv_a = 1'b0;
        fs_a = 1'b0;
    endtask

    task automatic drv_b(input logic [7:0] pix, input logic fs, input bit ev,
                         input logic [71:0] ew, input bit ed);
        exp_t e;
        pix_b = pix;
        fs_b  = fs;
        pv_b  = 1'b1;
        if (ev) begin
            e.w = ew; e.d = ed; e.cyc = cyc + 1;
            q_b.push_back(e);
        end
        @(posedge clk); #1;
        pv_b = 1'b0;
        fs_b = 1'b0;
    endtask

    // Idle cycle with a stray frame_start that must be ignored
    task automatic idle_a();
        pv_a  = 1'b0;
        fs_a  = 1'b1;
        pix_a = 8'($urandom);
        @(posedge clk); #1;
        fs_a = 1'b0;
    endtask

    task automatic send_frame_a(input int base, input bit gap, input bit use_fs, input int n);
        for (int idx = 0; idx < n; idx++) begin
            int r, c;
            bit ev;
            logic [71:0] ew;
            r = idx / 4;
            c = idx % 4;
            img[r][c] = (base + idx) & 255;
            ev = (r >= 2) && (c >= 2);
            ew = '0;
            if (ev)
                ew = w9(img[r-2][c-2], img[r-2][c-1], img[r-2][c],
                        img[r-1][c-2], img[r-1][c-1], img[r-1][c],
                        img[r][c-2],   img[r][c-1],   img[r][c]);
            drv_a(8'(img[r][c]), use_fs && (idx == 0), ev, ew, (r == 3) && (c == 3));
            if (gap) idle_a();
        end
    endtask

    task automatic drain();
        repeat (4) @(posedge clk);
        #1;
        check("drain_A", 72'(q_a.size()), 72'(0));
        check("drain_B", 72'(q_b.size()), 72'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        pix_a = '0; pv_a = 1'b0; fs_a = 1'b0;
        pix_b = '0; pv_b = 1'b0; fs_b = 1'b0;

        for (int i = 0; i < 16; i++) begin
            tbl[i].pix = 8'(i);
            tbl[i].fs  = (i == 0);
            tbl[i].ev  = 1'b0;
            tbl[i].ew  = '0;
            tbl[i].ed  = 1'b0;
        end
        tbl[10].ev = 1'b1; tbl[10].ew = w9(0, 1, 2, 4, 5, 6, 8, 9, 10);
        tbl[11].ev = 1'b1; tbl[11].ew = w9(1, 2, 3, 5, 6, 7, 9, 10, 11);
        tbl[14].ev = 1'b1; tbl[14].ew = w9(4, 5, 6, 8, 9, 10, 12, 13, 14);
        tbl[15].ev = 1'b1; tbl[15].ew = w9(5, 6, 7, 9, 10, 11, 13, 14, 15);
        tbl[15].ed = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_window", w_a, 72'(0));
        check("reset_valid", 72'(wv_a), 72'(0));
        check("reset_done", 72'(fd_a), 72'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        // Continuous ramp from the table
        for (int i = 0; i < 16; i++)
            drv_a(tbl[i].pix, tbl[i].fs, tbl[i].ev, tbl[i].ew, tbl[i].ed);
        drain();

        // Same ramp with a gap after every pixel
        for (int i = 0; i < 16; i++) begin
            drv_a(tbl[i].pix, tbl[i].fs, tbl[i].ev, tbl[i].ew, tbl[i].ed);
            idle_a();
        end
        drain();

        // Back-to-back frames, second offset by 100
        send_frame_a(0, 1'b0, 1'b1, 16);
        send_frame_a(100, 1'b0, 1'b1, 16);
        drain();

        // Reset after 7 pixels; reset wins over a valid pixel
        send_frame_a(50, 1'b0, 1'b1, 7);
        rst = 1'b1; pv_a = 1'b1; fs_a = 1'b1; pix_a = 8'd99;
        @(posedge clk);
        @(negedge clk);
        check("midreset_window", w_a, 72'(0));
        check("midreset_valid", 72'(wv_a), 72'(0));
        check("midreset_done", 72'(fd_a), 72'(0));
        @(posedge clk); #1;
        rst = 1'b0; pv_a = 1'b0; fs_a = 1'b0;
        send_frame_a(200, 1'b0, 1'b0, 16);
        drain();

        // frame_start reasserted at pixel 9 abandons the partial frame
        send_frame_a(30, 1'b0, 1'b1, 9);
        send_frame_a(150, 1'b0, 1'b1, 16);
        drain();

        // 5x3 frame valued 1..15: centres 7, 8, 9
        for (int i = 0; i < 15; i++) begin
            bit ev;
            logic [71:0] ew;
            ev = (i >= 12);
            ew = '0;
            if (i == 12) ew = w9(1, 2, 3, 6, 7, 8, 11, 12, 13);
            if (i == 13) ew = w9(2, 3, 4, 7, 8, 9, 12, 13, 14);
            if (i == 14) ew = w9(3, 4, 5, 8, 9, 10, 13, 14, 15);
            drv_b(8'(i + 1), (i == 0), ev, ew, (i == 14));
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
